div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/riscv_m_pkg.sv | 43 ++++
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 183 ++++++++++++++++++
 tb/tb_div_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M divide path.
// Holds the datapath width, the M-extension encodings seen by the decoder,
// the divider state encoding and small func3 decode helpers.
package riscv_m_pkg;

  // Operand / result width.
  localparam int XLEN = 32;

  // Major opcode and funct7 that select the M extension.
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // func3 codes of the divide family.
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Divider FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // True when the decoded instruction belongs to the divide family.
  function automatic logic is_div_instr(input logic [6:0] opcode,
                                        input logic [6:0] funct7,
                                        input logic [2:0] funct3);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && funct3[2];
  endfunction

  // DIV and REM (func3[0]=0) treat operands as two's complement.
  function automatic logic is_signed_div(input logic [2:0] funct3);
    return ~funct3[0];
  endfunction

  // REM and REMU (func3[1]=1) return the remainder instead of the quotient.
  function automatic logic is_rem_op(input logic [2:0] funct3);
    return funct3[1];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Bundle between the EX stage and the iterative divider.
// master (pipeline side) drives: start, func3, op1, op2, flush
// slave  (divider side)  drives: stall, busy, done, result
interface div_unit_if #(
  parameter int XLEN = 32
);

  logic            start;   // divide instruction present in EX
  logic [2:0]      func3;   // DIV / DIVU / REM / REMU
  logic [XLEN-1:0] op1;     // dividend
  logic [XLEN-1:0] op2;     // divisor
  logic            flush;   // abort current operation
  logic            stall;   // freeze PC, IF/ID, ID/EX
  logic            busy;    // divider not idle
  logic            done;    // one-cycle result-valid pulse
  logic [XLEN-1:0] result;  // quotient or remainder

  modport master (
    output start, func3, op1, op2, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, func3, op1, op2, flush,
    output stall, busy, done, result
  );

endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV, DIVU, REM, REMU).
// Restoring radix-2, one quotient bit per cycle. Divide-by-zero and signed
// overflow are resolved in one cycle without iterating.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - div_unit_if.slave: start/func3/op1/op2/flush in,
//          stall/busy/done/result out
module div_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = riscv_m_pkg::XLEN
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v,
                                                input logic            neg);
    logic [XLEN-1:0] r;
    if (neg) begin
      r = (~v) + XLEN'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Registered state
  div_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  divisor_r;   // |op2|
  logic [XLEN-1:0]  quot_r;      // shifts out dividend bits, shifts in quotient bits
  logic [XLEN:0]    rem_r;       // partial remainder, one guard bit
  logic             neg_q_r;     // quotient must be negated
  logic             neg_r_r;     // remainder must be negated
  logic             is_rem_r;    // return remainder
  logic             done_r;
  logic [XLEN-1:0]  result_r;

  // Combinational decode / datapath
  logic             signed_op_s;
  logic             op1_neg_s;
  logic             op2_neg_s;
  logic             div_zero_s;
  logic             overflow_s;
  logic [XLEN-1:0]  special_res_s;
  logic [XLEN:0]    rem_shift_s;
  logic [XLEN:0]    diff_s;
  logic             q_bit_s;
  logic [XLEN:0]    rem_next_s;
  logic [XLEN-1:0]  quot_next_s;
  logic [XLEN-1:0]  final_res_s;
  logic             stall_s;

  // Operand classification and single-cycle special-case results.
  always_comb begin
    signed_op_s   = is_signed_div(bus.func3);
    op1_neg_s     = signed_op_s & bus.op1[XLEN-1];
    op2_neg_s     = signed_op_s & bus.op2[XLEN-1];
    div_zero_s    = (bus.op2 == ZERO);
    overflow_s    = signed_op_s & (bus.op1 == MIN_NEG) & (bus.op2 == ALL_ONES);
    special_res_s = ZERO;
    if (div_zero_s) begin
      // x/0: quotient all ones, remainder is the dividend untouched.
      special_res_s = is_rem_op(bus.func3) ? bus.op1 : ALL_ONES;
    end else if (overflow_s) begin
      special_res_s = is_rem_op(bus.func3) ? ZERO : MIN_NEG;
    end else begin
      special_res_s = ZERO;
    end
  end

  // One restoring step: shift in next dividend bit, try subtracting divisor.
  always_comb begin
    rem_shift_s = {rem_r[XLEN-1:0], quot_r[XLEN-1]};
    diff_s      = rem_shift_s - {1'b0, divisor_r};
    // A clear guard bit means the subtraction did not go negative.
    q_bit_s     = ~diff_s[XLEN];
    if (q_bit_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = rem_shift_s;
    end
    quot_next_s = {quot_r[XLEN-2:0], q_bit_s};
  end

  // Sign fix-up of the values produced by the final step.
  always_comb begin
    if (is_rem_r) begin
      final_res_s = negate_if(rem_next_s[XLEN-1:0], neg_r_r);
    end else begin
      final_res_s = negate_if(quot_next_s, neg_q_r);
    end
  end

  // Pipeline hold request; drops in DONE so the divide instruction leaves EX.
  always_comb begin
    stall_s = ((state_r == ST_IDLE) & bus.start & ~bus.flush) |
              (state_r == ST_CALC);
  end

  assign bus.stall  = stall_s;
  assign bus.busy   = (state_r != ST_IDLE);
  assign bus.done   = done_r;
  assign bus.result = result_r;

  // FSM, iteration registers and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      divisor_r <= ZERO;
      quot_r    <= ZERO;
      rem_r     <= {(XLEN+1){1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      is_rem_r  <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= ZERO;
    end else if (bus.flush) begin
      // Redirect kills the instruction: no done pulse, result untouched.
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            if (div_zero_s || overflow_s) begin
              result_r <= special_res_s;
              done_r   <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              divisor_r <= negate_if(bus.op2, op2_neg_s);
              quot_r    <= negate_if(bus.op1, op1_neg_s);
              rem_r     <= {(XLEN+1){1'b0}};
              neg_q_r   <= op1_neg_s ^ op2_neg_s;
              neg_r_r   <= op1_neg_s;
              is_rem_r  <= is_rem_op(bus.func3);
              cnt_r     <= {CNT_W{1'b0}};
              state_r   <= ST_CALC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_r  <= rem_next_s;
          quot_r <= quot_next_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            result_r <= final_res_s;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            done_r  <= 1'b0;
            state_r <= ST_CALC;
          end
        end
        ST_DONE: begin
          // start is still high for the same instruction; do not restart.
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;
  import riscv_m_pkg::*;

  logic clk;
  logic rst;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge (cycle 0). Holds start until done is seen,
  // returns just after the edge that ends the done cycle, start still high.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output logic stall_ok);
    bus.start = 1'b1;
    bus.func3 = f3;
    bus.op1   = a;
    bus.op2   = b;
    done_cyc  = -1;
    stall_ok  = 1'b1;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic op_check(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_cyc);
    int   dc;
    logic sok;
    run_op(f3, a, b, dc, sok);
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_latency"}, 32'(dc), 32'(exp_cyc));
    chk({tag, "_stall"}, {31'd0, sok}, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   dc;
    logic sok;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.func3 = 3'b000;
    bus.op1   = 32'd0;
    bus.op2   = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;

    // Normal operations
    op_check("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
    op_check("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 33);
    op_check("div_m20_3",  F3_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    op_check("rem_m20_3",  F3_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    op_check("rem_20_m3",  F3_REM,  32'd20, 32'hFFFF_FFFD, 32'd2, 33);
    op_check("div_20_m3",  F3_DIV,  32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    op_check("div_m20_m3", F3_DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6, 33);
    op_check("divu_big_1", F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    op_check("divu_ovf_unsigned", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // Special cases
    op_check("divu_5_0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    op_check("rem_5_0",  F3_REM,  32'd5, 32'd0, 32'd5, 1);
    op_check("div_ovf",  F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op_check("rem_ovf",  F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    op_check("remu_big_10", F3_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 33);

    // Flush at CALC cycle 10
    bus.start = 1'b1;
    bus.func3 = F3_DIVU;
    bus.op1   = 32'd1000;
    bus.op2   = 32'd3;
    repeat (10) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("flush_busy_before", {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    chk("flush_stall", {31'd0, bus.stall}, 32'd0);
    chk("flush_result_held", bus.result, 32'd5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_done_later", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;
    op_check("after_flush_divu", F3_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    // Reset at CALC cycle 20
    bus.start = 1'b1;
    bus.func3 = F3_DIVU;
    bus.op1   = 32'd1000;
    bus.op2   = 32'd7;
    repeat (20) begin
      @(posedge clk); #1;
    end
    rst       = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_done_later", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back: second start in the cycle right after DONE
    run_op(F3_DIVU, 32'd1000, 32'd7, dc, sok);
    chk("b2b_first_result", bus.result, 32'd142);
    chk("b2b_first_latency", 32'(dc), 32'd33);
    run_op(F3_DIVU, 32'd1000, 32'd9, dc, sok);
    chk("b2b_second_result", bus.result, 32'd111);
    chk("b2b_second_latency_abs", 32'(dc + 34), 32'd67);
    chk("b2b_second_stall", {31'd0, sok}, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_idle_after", {31'd0, bus.busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
